// File: rtl/router_pkg.sv
// Shared constants and types for the 8x8 serial router output-side logic.
// Frame on the wire: destination address, one pad bit, then the payload.
package router_pkg;
  localparam int NUM_PORTS    = 8;
  localparam int ADDR_BITS    = 3;
  localparam int PAD_BITS     = 1;
  localparam int PAYLOAD_BITS = 32;
  localparam int PACKET_BITS  = ADDR_BITS + PAD_BITS + PAYLOAD_BITS;
  localparam int MAX_HOLD     = 64;

  typedef logic [$clog2(NUM_PORTS)-1:0] port_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;
endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping; purely combinational.
// No latency, no backpressure; found=0 when no request is pending.
module rr_priority_pick #(
  parameter int  NUM_PORTS = 8,
  localparam int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic                 found,
  output logic [IDX_W-1:0]     idx
);

  localparam logic [IDX_W:0] PORTS_W = (IDX_W+1)'(NUM_PORTS);

  logic [NUM_PORTS-1:0] rot;
  logic [IDX_W-1:0]     rot_idx;
  logic [IDX_W:0]       sum;
  logic [IDX_W:0]       abs_sum;

  // Rotate so ptr lands at bit 0, then the lowest set bit is the winner.
  always_comb begin
    rot = '0;
    sum = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sum = {1'b0, IDX_W'(i)} + {1'b0, ptr};
      if (sum >= PORTS_W) begin
        sum = sum - PORTS_W;
      end
      rot[i] = req[sum[IDX_W-1:0]];
    end
  end

  always_comb begin
    rot_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (rot[i]) begin
        rot_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    found   = |rot;
    abs_sum = {1'b0, rot_idx} + {1'b0, ptr};
    if (abs_sum >= PORTS_W) begin
      abs_sum = abs_sum - PORTS_W;
    end
    idx = abs_sum[IDX_W-1:0];
  end

endmodule

// File: rtl/router_out_arbiter.sv
// Per-output-port round-robin arbiter: grant held until eop, abort, or watchdog expiry.
// Grant registered one cycle after request; one idle cycle after every release.
module router_out_arbiter
  import router_pkg::*;
#(
  parameter int  NUM_PORTS = router_pkg::NUM_PORTS,
  parameter int  MAX_HOLD  = router_pkg::MAX_HOLD,
  localparam int IDX_W     = $clog2(NUM_PORTS),
  localparam int HOLD_W    = $clog2(MAX_HOLD)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_PORTS-1:0] req,
  input  logic [NUM_PORTS-1:0] eop,
  output logic [NUM_PORTS-1:0] grant,
  output logic                 grant_valid,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 timeout
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [IDX_W-1:0]  LAST_PORT = IDX_W'(NUM_PORTS - 1);

  arb_state_t           state_q;
  arb_state_t           state_d;
  logic [IDX_W-1:0]     ptr_q;
  logic [IDX_W-1:0]     ptr_d;
  logic [HOLD_W-1:0]    hold_cnt_q;
  logic [HOLD_W-1:0]    hold_cnt_d;
  logic [NUM_PORTS-1:0] grant_d;
  logic [IDX_W-1:0]     grant_idx_d;
  logic                 timeout_d;

  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;
  logic                 owner_eop;
  logic                 owner_req;
  logic                 watchdog;

  rr_priority_pick #(
    .NUM_PORTS (NUM_PORTS)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // The registered one-hot grant masks out every non-owner eop/req.
  assign owner_eop = |(eop & grant);
  assign owner_req = |(req & grant);
  assign watchdog  = (hold_cnt_q == HOLD_LAST);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    grant_d     = grant;
    grant_idx_d = grant_idx;
    timeout_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          for (int i = 0; i < NUM_PORTS; i++) begin
            grant_d[i] = (IDX_W'(i) == pick_idx);
          end
          grant_idx_d = pick_idx;
          hold_cnt_d  = '0;
          state_d     = BUSY;
        end
      end

      BUSY: begin
        if (!watchdog) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
        if (owner_eop || !owner_req || watchdog) begin
          grant_d     = '0;
          grant_idx_d = '0;
          ptr_d       = (grant_idx == LAST_PORT) ? '0 : grant_idx + 1'b1;
          state_d     = IDLE;
          // A normal end of frame or abort wins over an expiring watchdog.
          timeout_d   = owner_req && !owner_eop;
        end
      end

      default: begin
        state_d     = IDLE;
        grant_d     = '0;
        grant_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      timeout     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      grant       <= grant_d;
      grant_valid <= |grant_d;
      grant_idx   <= grant_idx_d;
      timeout     <= timeout_d;
    end
  end

endmodule
